// File: rtl/p_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
// Used by p_divider; the optional error fast path is enabled with DIV_ERR_CHECK_EN.
package p_div_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/p_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and emit the resulting quotient bit.
module p_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH:0] t_s;
  logic [WIDTH:0] dvs_ext_s;
  // The top bit of P is zero whenever P < divisor holds, so it never enters T.
  logic           unused_p_msb_s;

  assign unused_p_msb_s = p_in[WIDTH];
  assign t_s            = {p_in[WIDTH-1:0], bit_in};
  assign dvs_ext_s      = {1'b0, divisor};

  // Trial subtraction with restore.
  always_comb begin
    p_out = t_s;
    q_bit = 1'b0;
    if (t_s >= dvs_ext_s) begin
      p_out = t_s - dvs_ext_s;
      q_bit = 1'b1;
    end else begin
      p_out = t_s;
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/p_divider.sv
// Iterative restoring divider, 2*WIDTH / WIDTH, one quotient bit per cycle.
// Define DIV_ERR_CHECK_EN for the divide-by-zero / overflow fast path and flags.
module p_divider
  import p_div_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_p_s;
  logic             step_q_s;

  p_div_step #(.WIDTH(WIDTH)) u_step (
    .p_in    (p_q),
    .bit_in  (q_q[WIDTH-1]),
    .divisor (dvs_q),
    .p_out   (step_p_s),
    .q_bit   (step_q_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d      = divisor;
          p_d        = {1'b0, dividend[2*WIDTH-1:WIDTH]};
          q_d        = dividend[WIDTH-1:0];
          cnt_d      = {CW{1'b0}};
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
`ifdef DIV_ERR_CHECK_EN
          if (divisor == {WIDTH{1'b0}}) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quot_d      = {WIDTH{1'b1}};
            rem_d       = dividend[WIDTH-1:0];
            dbz_d       = 1'b1;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            quot_d      = {WIDTH{1'b1}};
            rem_d       = {WIDTH{1'b0}};
            ovf_d       = 1'b1;
          end else begin
            state_d = RUN;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = step_p_s;
        q_d   = {q_q[WIDTH-2:0], step_q_s};
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quot_d      = {q_q[WIDTH-2:0], step_q_s};
          rem_d       = step_p_s[WIDTH-1:0];
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      p_q         <= {(WIDTH+1){1'b0}};
      q_q         <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= {WIDTH{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
